// File: rtl/timer_counter_if.sv
// Control/status bundle between the timer register block (master) and the timer core (slave).
interface timer_counter_if #(
    parameter int CNT_W = 64
) ();
    logic             timer_en;
    logic             div_en;
    logic [3:0]       div_val;
    logic             cnt_wr;
    logic [CNT_W-1:0] cnt_wdata;
    logic [CNT_W-1:0] cmp_val;
    logic             int_st_clear;
    logic             halt_req;
    logic [CNT_W-1:0] cnt;
    logic             int_st_set;
    logic             int_st;
    logic             halt_ack;

    modport master (
        output timer_en, div_en, div_val, cnt_wr, cnt_wdata, cmp_val, int_st_clear, halt_req,
        input  cnt, int_st_set, int_st, halt_ack
    );

    modport slave (
        input  timer_en, div_en, div_val, cnt_wr, cnt_wdata, cmp_val, int_st_clear, halt_req,
        output cnt, int_st_set, int_st, halt_ack
    );
endinterface

// File: rtl/timer_counter.sv
// Free-running timer: prescaler, loadable counter, compare-match pulse and sticky status.
// Optional debug halt support is built only when TIMER_HALT_EN is defined.
module timer_counter #(
    parameter int CNT_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    timer_counter_if.slave        bus
);

    logic [7:0]       r_div_cnt;
    logic             r_div_en_q;
    logic [3:0]       r_div_val_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_match_q;
    logic             r_int_st_set;
    logic             r_int_st;

    logic [3:0]       w_eff;
    logic [7:0]       w_period_m1;
    logic             w_cfg_chg;
    logic             w_halted;
    logic             w_tick;
    logic [7:0]       w_div_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_match;

`ifdef TIMER_HALT_EN
    logic             r_halt_ack;

    assign w_halted     = bus.halt_req;
    assign bus.halt_ack = r_halt_ack;

    // Halt acknowledge follows the request one cycle later, only while the timer is enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_halt_ack <= 1'b0;
        end else begin
            r_halt_ack <= bus.halt_req & bus.timer_en;
        end
    end
`else
    // Without halt support the request is consumed but can never freeze the timer.
    assign w_halted     = bus.halt_req & 1'b0;
    assign bus.halt_ack = 1'b0;
`endif

    assign w_eff       = (bus.div_val > 4'd8) ? 4'd8 : bus.div_val;
    assign w_period_m1 = 8'hFF >> (4'd8 - w_eff);
    assign w_cfg_chg   = (bus.div_en != r_div_en_q) | (bus.div_val != r_div_val_q);
    assign w_match     = (r_cnt == bus.cmp_val);

    // Prescaler: restart on disable or config change, freeze mid-period while halted.
    always_comb begin
        w_tick        = 1'b0;
        w_div_cnt_nxt = r_div_cnt;
        if (!bus.timer_en || w_cfg_chg) begin
            w_div_cnt_nxt = 8'd0;
        end else if (w_halted) begin
            w_div_cnt_nxt = r_div_cnt;
        end else if (!bus.div_en) begin
            w_tick        = 1'b1;
            w_div_cnt_nxt = 8'd0;
        end else if (r_div_cnt == w_period_m1) begin
            w_tick        = 1'b1;
            w_div_cnt_nxt = 8'd0;
        end else begin
            w_div_cnt_nxt = r_div_cnt + 8'd1;
        end
    end

    // Counter next value: software load beats tick; increment wraps silently.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (bus.cnt_wr) begin
            w_cnt_nxt = bus.cnt_wdata;
        end else if (w_tick) begin
            w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // State registers: prescaler, config history, counter, match edge detect and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt    <= 8'd0;
            r_div_en_q   <= 1'b0;
            r_div_val_q  <= 4'd0;
            r_cnt        <= {CNT_W{1'b0}};
            r_match_q    <= 1'b0;
            r_int_st_set <= 1'b0;
            r_int_st     <= 1'b0;
        end else begin
            r_div_cnt    <= w_div_cnt_nxt;
            r_div_en_q   <= bus.div_en;
            r_div_val_q  <= bus.div_val;
            r_cnt        <= w_cnt_nxt;
            r_match_q    <= w_match;
            r_int_st_set <= w_match & ~r_match_q;
            if (r_int_st_set) begin
                r_int_st <= 1'b1;
            end else if (bus.int_st_clear) begin
                r_int_st <= 1'b0;
            end else begin
                r_int_st <= r_int_st;
            end
        end
    end

    assign bus.cnt        = r_cnt;
    assign bus.int_st_set = r_int_st_set;
    assign bus.int_st     = r_int_st;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the timer.
module tb_timer_counter;
    localparam int CNT_W = 64;
`ifdef TIMER_HALT_EN
    localparam bit HALT_ON = 1'b1;
`else
    localparam bit HALT_ON = 1'b0;
`endif

    logic clk;
    logic rst;
    timer_counter_if #(.CNT_W(CNT_W)) tif ();

    timer_counter #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (tif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [63:0] m_cnt;
    int          m_elapsed;
    bit          m_prev_div_en;
    logic [3:0]  m_prev_div_val;
    bit          m_prev_eq;
    bit          m_set;
    bit          m_st;
    bit          m_ack;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        int eff;
        int period;
        bit cfg_changed;
        bit tick;
        bit eq_now;
        bit halted;
        if (rst) begin
            m_cnt = 64'd0; m_elapsed = 0; m_prev_div_en = 1'b0; m_prev_div_val = 4'd0;
            m_prev_eq = 1'b0; m_set = 1'b0; m_st = 1'b0; m_ack = 1'b0;
            return;
        end
        eq_now      = (m_cnt == tif.cmp_val);
        eff         = (int'(tif.div_val) > 8) ? 8 : int'(tif.div_val);
        period      = 1 << eff;
        cfg_changed = (tif.div_en != m_prev_div_en) || (tif.div_val != m_prev_div_val);
        halted      = HALT_ON && tif.halt_req;
        tick        = 1'b0;
        if (!tif.timer_en || cfg_changed) begin
            m_elapsed = 0;
        end else if (!halted) begin
            if (!tif.div_en) begin
                tick = 1'b1;
            end else begin
                m_elapsed++;
                if (m_elapsed == period) begin
                    tick = 1'b1;
                    m_elapsed = 0;
                end
            end
        end
        m_st      = m_set ? 1'b1 : (tif.int_st_clear ? 1'b0 : m_st);
        m_set     = eq_now && !m_prev_eq;
        m_prev_eq = eq_now;
        if (tif.cnt_wr) m_cnt = tif.cnt_wdata;
        else if (tick)  m_cnt = m_cnt + 64'd1;
        m_ack          = HALT_ON && tif.halt_req && tif.timer_en;
        m_prev_div_en  = tif.div_en;
        m_prev_div_val = tif.div_val;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("cnt", tif.cnt, m_cnt);
        chk("int_st_set", 64'(tif.int_st_set), 64'(m_set));
        chk("int_st", 64'(tif.int_st), 64'(m_st));
        chk("halt_ack", 64'(tif.halt_ack), 64'(m_ack));
    endtask

    task automatic wait_inc(input int limit, output int n);
        logic [63:0] start;
        start = tif.cnt;
        n = 0;
        while (tif.cnt == start && n < limit) begin
            cycle();
            n++;
        end
    endtask

    task automatic count_pulses(input int ncyc, output int pulses);
        pulses = 0;
        for (int k = 0; k < ncyc; k++) begin
            cycle();
            if (tif.int_st_set) pulses++;
        end
    endtask

    task automatic load(input logic [63:0] v);
        tif.cnt_wr = 1'b1; tif.cnt_wdata = v;
        cycle();
        tif.cnt_wr = 1'b0;
    endtask

    initial begin
        int n;
        int p;
        rst = 1'b1;
        tif.timer_en = 1'b0; tif.div_en = 1'b0; tif.div_val = 4'd0;
        tif.cnt_wr = 1'b0; tif.cnt_wdata = 64'd0; tif.cmp_val = 64'd5;
        tif.int_st_clear = 1'b0; tif.halt_req = 1'b0;
        m_cnt = 64'd0; m_elapsed = 0; m_prev_div_en = 1'b0; m_prev_div_val = 4'd0;
        m_prev_eq = 1'b0; m_set = 1'b0; m_st = 1'b0; m_ack = 1'b0;
        cycle(); cycle();
        chk("rst_cnt", tif.cnt, 64'd0);
        chk("rst_int_st", 64'(tif.int_st), 64'd0);

        // Undivided counting to compare value 5
        rst = 1'b0; tif.timer_en = 1'b1;
        for (int k = 0; k < 5; k++) cycle();
        chk("cnt_at_5", tif.cnt, 64'd5);
        chk("no_set_yet", 64'(tif.int_st_set), 64'd0);
        cycle();
        chk("set_pulse", 64'(tif.int_st_set), 64'd1);
        cycle();
        chk("st_rise", 64'(tif.int_st), 64'd1);
        chk("set_one_cycle", 64'(tif.int_st_set), 64'd0);
        cycle(); cycle();
        chk("st_sticky", 64'(tif.int_st), 64'd1);

        // Prescaler periods and restart on div_val change
        tif.cmp_val = 64'hDEAD_0000; tif.div_en = 1'b1; tif.div_val = 4'd3;
        wait_inc(600, n);
        wait_inc(600, n);
        chk("period_div3", 64'(n), 64'd8);
        tif.div_val = 4'd12;
        wait_inc(600, n);
        wait_inc(600, n);
        chk("period_div12", 64'(n), 64'd256);
        tif.div_val = 4'd3;
        wait_inc(600, n);
        wait_inc(600, n);
        chk("period_div3_again", 64'(n), 64'd8);
        cycle(); cycle(); cycle();
        tif.div_val = 4'd2;
        wait_inc(600, n);
        chk("restart_on_change", 64'(n), 64'd5);

        // Wrap from all-ones without a flag, then a matching load
        tif.timer_en = 1'b0; tif.div_en = 1'b0; tif.cmp_val = 64'd10;
        cycle(); cycle();
        tif.timer_en = 1'b1;
        load(64'hFFFF_FFFF_FFFF_FFFF);
        cycle();
        chk("wrap_to_zero", tif.cnt, 64'd0);
        count_pulses(3, p);
        chk("wrap_no_pulse", 64'(p), 64'd0);
        tif.timer_en = 1'b0;
        load(64'd10);
        count_pulses(6, p);
        chk("load_match_pulse", 64'(p), 64'd1);

        // Stopped on match: one pulse only; set beats clear
        tif.int_st_clear = 1'b1; cycle(); tif.int_st_clear = 1'b0;
        tif.cmp_val = 64'd7;
        load(64'd7);
        count_pulses(20, p);
        chk("stopped_match_pulse", 64'(p), 64'd1);
        tif.int_st_clear = 1'b1; cycle(); tif.int_st_clear = 1'b0;
        chk("st_cleared", 64'(tif.int_st), 64'd0);
        tif.cmp_val = 64'd9;
        load(64'd9);
        cycle();
        chk("set_visible", 64'(tif.int_st_set), 64'd1);
        tif.int_st_clear = 1'b1;
        cycle();
        chk("set_beats_clear", 64'(tif.int_st), 64'd1);
        cycle();
        chk("clear_after", 64'(tif.int_st), 64'd0);
        tif.int_st_clear = 1'b0;

        // Debug halt at cnt=3
        tif.cmp_val = 64'd1000;
        load(64'd3);
        tif.timer_en = 1'b1; tif.halt_req = 1'b1;
        cycle();
        chk("halt_ack_next", 64'(tif.halt_ack), HALT_ON ? 64'd1 : 64'd0);
        for (int k = 0; k < 9; k++) cycle();
        chk("halt_cnt", tif.cnt, HALT_ON ? 64'd3 : 64'd13);
        tif.halt_req = 1'b0;
        cycle(); cycle(); cycle();
        chk("halt_resume", tif.cnt, HALT_ON ? 64'd6 : 64'd16);

        // Reset one cycle before an expected match
        tif.timer_en = 1'b0; tif.cmp_val = 64'd22;
        load(64'd20);
        tif.timer_en = 1'b1;
        cycle();
        rst = 1'b1;
        cycle();
        chk("rst_mid_cnt", tif.cnt, 64'd0);
        chk("rst_mid_set", 64'(tif.int_st_set), 64'd0);
        chk("rst_mid_st", 64'(tif.int_st), 64'd0);
        rst = 1'b0; tif.timer_en = 1'b0;
        count_pulses(5, p);
        chk("rst_no_pulse", 64'(p), 64'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            tif.timer_en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) tif.div_en = ~tif.div_en;
            if ($urandom_range(0, 39) == 0)
                tif.div_val = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            tif.cnt_wr = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 2))
                0:       tif.cnt_wdata = tif.cmp_val - 64'($urandom_range(0, 3));
                1:       tif.cnt_wdata = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 2));
                default: tif.cnt_wdata = {32'($urandom), 32'($urandom)};
            endcase
            if ($urandom_range(0, 29) == 0) tif.cmp_val = m_cnt + 64'($urandom_range(0, 4));
            tif.int_st_clear = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 14) == 0) tif.halt_req = ~tif.halt_req;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
